// File: rtl/wm_phase_timer.sv
// wm_phase_timer: per-phase countdown for the washer controller.
// Prescaled tick, mode scaling, lid pause, one-shot done pulse.
module wm_phase_timer #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 12,
  parameter int SOAK_T   = 10,
  parameter int WASH_T   = 20,
  parameter int RINSE_T  = 15,
  parameter int SPIN_T   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_enable,
  input  logic [1:0]       phase_sel,
  input  logic             mode1,
  input  logic             mode2,
  input  logic             mode3,
  input  logic             lid,
  output logic             timer_done,
  output logic [CNT_W-1:0] remaining,
  output logic             running,
  output logic             paused
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic [2:0]       state;
  logic [1:0]       phase_q;
  logic [PW-1:0]    pre;
  logic [CNT_W-1:0] base;
  logic [CNT_W:0]   dbl;
  logic [CNT_W-1:0] scaled;
  logic             tick;
  logic             last;
  logic             ph_chg;

  // base duration of the requested phase
  always_comb begin
    base = '0;
    case (phase_sel)
      2'b00:   base = CNT_W'(SOAK_T);
      2'b01:   base = CNT_W'(WASH_T);
      2'b10:   base = CNT_W'(RINSE_T);
      default: base = CNT_W'(SPIN_T);
    endcase
  end

  // mode scaling by priority, saturating double, never zero
  always_comb begin
    dbl    = {1'b0, base} << 1;
    scaled = base;
    case (1'b1)
      mode3:   scaled = base >> 1;
      mode2:   scaled = dbl[CNT_W] ? '1 : dbl[CNT_W-1:0];
      mode1:   scaled = base;
      default: scaled = base;
    endcase
    if (scaled == '0)
      scaled = CNT_W'(1);
  end

  // prescaler wrap and final-tick detection
  always_comb begin
    tick   = (pre == PW'(TICK_DIV - 1));
    last   = tick && (remaining == CNT_W'(1));
    ph_chg = (phase_sel != phase_q);
  end

  // phase state machine, prescaler and remaining counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase_q   <= '0;
      pre       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (timer_enable)
            state <= S_LOAD;
        end
        S_LOAD: begin
          phase_q   <= phase_sel;
          remaining <= scaled;
          pre       <= '0;
          state     <= S_RUN;
        end
        S_RUN, S_PAUSE: begin
          if (!timer_enable) begin
            state     <= S_IDLE;
            remaining <= '0;
          end else if (state == S_RUN && ph_chg) begin
            state <= S_LOAD;
          end else if (lid) begin
            state <= S_PAUSE;
          end else if (tick) begin
            pre       <= '0;
            remaining <= remaining - CNT_W'(1);
            state     <= last ? S_DONE : S_RUN;
          end else begin
            pre   <= pre + PW'(1);
            state <= S_RUN;
          end
        end
        S_DONE: begin
          remaining <= '0;
          if (!timer_enable)
            state <= S_IDLE;
          else if (ph_chg)
            state <= S_LOAD;
          else
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (!timer_enable)
            state <= S_IDLE;
          else if (ph_chg)
            state <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // status decoded from registered state only
  always_comb begin
    timer_done = (state == S_DONE);
    running    = (state == S_LOAD) || (state == S_RUN);
    paused     = (state == S_PAUSE);
  end

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb_wm_phase_timer: random and directed checks of wm_phase_timer
// against a work-count model of the phase timer.
module tb_wm_phase_timer;

  localparam int TD = 4;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    psel;
  logic          m1, m2, m3;
  logic          lid;
  logic          timer_done;
  logic [CW-1:0] remaining;
  logic          running;
  logic          paused;

  int checks = 0;
  int errors = 0;

  wm_phase_timer #(
    .TICK_DIV(TD), .CNT_W(CW), .SOAK_T(3),
    .WASH_T(5), .RINSE_T(3), .SPIN_T(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .timer_enable(en),
    .phase_sel(psel), .mode1(m1), .mode2(m2),
    .mode3(m3), .lid(lid), .timer_done(timer_done),
    .remaining(remaining), .running(running),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dur(input logic [1:0] p,
                             input logic a2, input logic a3);
    int b;
    case (p)
      2'd0:    b = 3;
      2'd1:    b = 5;
      2'd2:    b = 3;
      default: b = 0;
    endcase
    if (a3)
      b = b / 2;
    else if (a2)
      b = (b * 2 > 4095) ? 4095 : b * 2;
    if (b == 0)
      b = 1;
    return b;
  endfunction

  // the phase needs d*TD counting cycles; a cycle from cycle 2 on
  // counts when the lid is closed and the phase is not finished
  task automatic run_phase(input logic [1:0] ph,
                           input logic a1, input logic a2,
                           input logic a3, input int lmode,
                           input int exp_dc);
    int d, total, work, wprev, td, got;
    logic l, lp, edone, epau, erun;
    int erem;
    d     = dur(ph, a2, a3);
    total = d * TD;
    work  = 0;
    wprev = 0;
    lp    = 1'b0;
    td    = -1;
    got   = -1;
    for (int t = 0; t < 2000; t++) begin
      en   = 1'b1;
      psel = ph;
      if (t < 2)
        {m1, m2, m3} = {a1, a2, a3};
      else
        {m1, m2, m3} = 3'($urandom);
      if (work >= total)
        l = 1'b0;
      else if (lmode == 1)
        l = ($urandom_range(0, 5) == 0);
      else if (lmode == 2)
        l = (t >= 6 && t <= 12);
      else
        l = 1'b0;
      lid   = l;
      edone = (t >= 2) && (work == total) && (wprev < total);
      epau  = lp && (t >= 3) && (wprev < total);
      erun  = (t == 1) || (t >= 2 && work < total && !epau);
      erem  = (t < 2) ? 0 : d - work / TD;
      @(negedge clk);
      check("done", int'(timer_done), int'(edone));
      check("paused", int'(paused), int'(epau));
      check("running", int'(running), int'(erun));
      check("remaining", int'(remaining), erem);
      if (timer_done && got < 0)
        got = t;
      if (edone)
        td = t;
      wprev = work;
      if (t >= 2 && !l && work < total)
        work++;
      lp = l;
      if (td >= 0 && t == td + 3)
        break;
      step();
    end
    check("done_cyc_model", got, td);
    if (exp_dc >= 0)
      check("done_cyc", got, exp_dc);
    step();
    en  = 1'b0;
    lid = 1'b0;
    @(negedge clk);
    check("wait_done", int'(timer_done), 0);
    step();
  endtask

  initial begin
    int pulses;
    rst_n = 1'b1;
    en = 1'b0; psel = 2'd0; lid = 1'b0;
    m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_running", int'(running), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_done", int'(timer_done), 0);
    check("rst_paused", int'(paused), 0);
    #19 rst_n = 1'b1;
    step();
    step();

    run_phase(2'd0, 1'b1, 1'b0, 1'b0, 0, 14);
    run_phase(2'd1, 1'b0, 1'b1, 1'b0, 0, 42);
    run_phase(2'd2, 1'b0, 1'b0, 1'b1, 0, 6);
    run_phase(2'd3, 1'b1, 1'b0, 1'b0, 0, 6);
    run_phase(2'd1, 1'b0, 1'b1, 1'b1, 0, 10);
    run_phase(2'd0, 1'b1, 1'b0, 1'b0, 2, 21);
    for (int i = 0; i < 12; i++)
      run_phase(2'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1, -1);

    // abort by dropping enable, then re-enable and switch phase
    psel = 2'd0; m1 = 1'b1; m2 = 1'b0; m3 = 1'b0; lid = 1'b0;
    pulses = 0;
    for (int t = 0; t < 15; t++) begin
      en = (t < 8);
      @(negedge clk);
      if (timer_done) pulses++;
      if (t == 2) check("ab_rem_load", int'(remaining), 3);
      if (t == 9) begin
        check("ab_running", int'(running), 0);
        check("ab_remaining", int'(remaining), 0);
      end
      step();
    end
    check("ab_pulses", pulses, 0);
    for (int t = 0; t < 9; t++) begin
      en = 1'b1;
      psel = (t >= 5) ? 2'd1 : 2'd0;
      @(negedge clk);
      if (t == 2) check("re_rem", int'(remaining), 3);
      if (t == 6) check("ph_load", int'(running), 1);
      if (t == 7) check("ph_rem", int'(remaining), 5);
      step();
    end
    en = 1'b0;
    step();
    step();

    // chaining: new phase the cycle after done
    pulses = 0;
    for (int t = 0; t < 25; t++) begin
      en = 1'b1;
      psel = (t >= 15) ? 2'd1 : 2'd0;
      @(negedge clk);
      if (timer_done) pulses++;
      if (t == 14) check("ch_done", int'(timer_done), 1);
      if (t == 16) check("ch_load", int'(running), 1);
      if (t == 17) check("ch_rem", int'(remaining), 5);
      step();
    end
    check("ch_pulses", pulses, 1);
    en = 1'b0;
    step();
    step();

    // hold phase after done: no refire
    pulses = 0;
    psel = 2'd0;
    for (int t = 0; t < 65; t++) begin
      en = 1'b1;
      @(negedge clk);
      if (timer_done) pulses++;
      step();
    end
    check("hold_pulses", pulses, 1);
    check("hold_rem", int'(remaining), 0);
    en = 1'b0;
    step();
    step();

    // asynchronous reset in the middle of RUN
    en = 1'b1;
    psel = 2'd0;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t == 6) check("ar_pre_run", int'(running), 1);
      if (t < 6) step();
    end
    #1 rst_n = 1'b0;
    #1;
    check("ar_running", int'(running), 0);
    check("ar_remaining", int'(remaining), 0);
    check("ar_done", int'(timer_done), 0);
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    check("ar_load", int'(running), 1);
    step();
    @(negedge clk);
    check("ar_reload", int'(remaining), 3);
    en = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm_phase_timer.md
# wm_phase_timer

Phase timer for the washing-machine controller. It consumes the controller's `timer_enable`, `phase_sel` and mode/lid inputs. It produces the single-cycle `timer_done` pulse that advances the controller through SOAK, WASH, RINSE and SPIN. It derives a one-second tick from `clk`, loads a per-phase duration scaled by the selected wash mode, counts it down, pauses while the lid is open, and exposes the remaining time.

## Interface
- `TICK_DIV`, 1000: `clk` cycles per timer tick (≥2).
- `CNT_W`, 12: width of the duration/remaining counter.
- `SOAK_T`, 10: base SOAK duration in ticks (`phase_sel`=00).
- `WASH_T`, 20: base WASH duration in ticks (01).
- `RINSE_T`, 15: base RINSE duration in ticks (10).
- `SPIN_T`, 8: base SPIN duration in ticks (11).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `timer_enable` in 1: controller requests timing of the current phase.
- `phase_sel` in 2: current phase code.
- `mode1`, `mode2`, `mode3` in 1 each: wash mode selects.
- `lid` in 1: 0 = closed, 1 = open.
- `timer_done` out 1: one-cycle pulse when the phase time expires.
- `remaining` out `CNT_W`: ticks left in the current phase.
- `running` out 1: high in LOAD or RUN.
- `paused` out 1: high in PAUSE.

## Operation
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset (`rst_n`=0, asynchronous):
  - state goes to IDLE;
  - `remaining`, prescaler and latched phase are 0;
  - `timer_done`, `running` and `paused` are 0.
- Mode scaling, evaluated in LOAD and selected by priority `mode3` > `mode2` > `mode1`/none:
  - `mode3`: base>>1;
  - `mode2`: base<<1, saturated to 2^`CNT_W`−1;
  - `mode1` or none: base.
- Any result of 0 is clamped to 1.
- States and transitions, checked in priority order:
  - IDLE: `timer_enable`=1 → LOAD.
  - LOAD (one cycle): latch `phase_sel` and the scaled duration; `remaining` ← duration; prescaler ← 0; → RUN. Mode is latched here; later mode changes have no effect until the next LOAD.
  - RUN:
    - `timer_enable`=0 → IDLE, `remaining` ← 0;
    - else `phase_sel` ≠ latched → LOAD;
    - else `lid`=1 → PAUSE, prescaler and `remaining` held;
    - else prescaler increments. At `TICK_DIV`−1 it wraps to 0 and `remaining` decrements. A decrement reaching 0 → DONE.
  - PAUSE:
    - `timer_enable`=0 → IDLE, `remaining` ← 0;
    - else `lid`=0 → RUN, resuming the held prescaler value (no tick lost or gained).
  - DONE (one cycle): `timer_done`=1, `remaining`=0.
    - `timer_enable`=0 → IDLE;
    - `phase_sel` ≠ latched → LOAD;
    - otherwise → WAIT.
  - WAIT: no counting, no pulse.
    - `timer_enable`=0 → IDLE;
    - `phase_sel` ≠ latched → LOAD.
- `timer_done` never re-fires for the same latched phase without passing through LOAD.
- Controller reset behaviour: after a power-fail reset the controller holds its state. The timer restarts that phase at full duration once `timer_enable` is seen in IDLE.

## Timing
- Cycle 0 is the first IDLE cycle with `timer_enable`=1.
  - LOAD in cycle 1.
  - First RUN cycle is cycle 2.
  - `timer_done` is high in cycle D·`TICK_DIV`+2, where D is the scaled duration, with the lid closed throughout.
- Each cycle spent in PAUSE delays `timer_done` by exactly one cycle. Each PAUSE episode costs one extra cycle only for the RUN→PAUSE edge decision; the total delay equals the number of cycles with `lid`=1 observed in RUN/PAUSE.
- Phase chaining:
  - the controller reacts to `timer_done` at the end of DONE cycle N;
  - the new `phase_sel` is visible in cycle N+1 (WAIT, or DONE→LOAD when already changed);
  - LOAD occurs in cycle N+2;
  - RUN starts in cycle N+3.
- `remaining` decrements on the clock edge ending a prescaler-wrap cycle. It is stable otherwise.
- Simultaneous events in RUN: `timer_enable` drop beats phase change, which beats lid open, which beats tick. A final tick coinciding with `lid`=1 does not occur; PAUSE wins and the tick happens after resume.

## Test plan
Bench parameters: `TICK_DIV`=4, `SOAK_T`=3, `WASH_T`=5, `RINSE_T`=3, `SPIN_T`=0.

- **SOAK, mode1, lid closed:** `phase_sel`=00, `mode1`=1, enable held. `remaining` 3→2→1→0 at 4-cycle spacing; `timer_done` high only in cycle 14.
- **Scaling and clamp:**
  - WASH with `mode2`: D=10, done in cycle 42.
  - RINSE with `mode3`: D=1, done in cycle 6.
  - SPIN with `mode1`: base 0 clamps to D=1, done in cycle 6.
  - WASH with `mode2`+`mode3` both set: `mode3` wins, D=2.
- **Lid open mid-phase:** SOAK `mode1`, `lid`=1 for 7 cycles starting cycle 6. `paused`=1 for those 7 cycles, `remaining` frozen, `timer_done` in cycle 21.
- **Abort and restart:**
  - Drop `timer_enable` in cycle 8: IDLE, `remaining`=0, no pulse.
  - Re-enable: full reload to 3.
  - Change `phase_sel` 00→01 mid-RUN: LOAD next cycle, `remaining`=5.
- **Chaining without double fire:**
  - After `timer_done`, change `phase_sel` 00→01 the next cycle: exactly one pulse, WASH loaded in cycle N+2.
  - Holding `phase_sel`=00 with enable high for 50 cycles after done: no second pulse.
- **Async reset:** assert `rst_n`=0 mid-RUN between clock edges. `running`, `remaining` and `timer_done` go to 0 immediately. After release with enable high, a full-duration reload occurs.
